// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core: FSM state encoding and default width.
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_comp.sv
// Unsigned magnitude comparator; exactly one of eq/lt/gt is high.
module comp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             eq_o,
    output logic             lt_o,
    output logic             gt_o
);

    // Pure combinational compare of a_i against b_i.
    always_comb begin
        eq_o = (a_i == b_i);
        lt_o = (a_i <  b_i);
        gt_o = (a_i >  b_i);
    end

endmodule : comp

// File: rtl/gcd_core.sv
// Subtractive GCD engine. One compare/subtract step per clock while in CALC.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; the only state in which start is sampled
// CALC  | one compare of A vs B per cycle, subtract smaller from larger
// DONE  | one-cycle result pulse; always returns to IDLE
module gcd_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             err
);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             err_q, err_d;
    logic             a_eq_b, a_lt_b, a_gt_b;

    comp #(
        .WIDTH (WIDTH)
    ) u_comp (
        .a_i  (a_q),
        .b_i  (b_q),
        .eq_o (a_eq_b),
        .lt_o (a_lt_b),
        .gt_o (a_gt_b)
    );

    // Next-state and datapath: operand load, subtraction step, result capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = a_in;
                    b_d = b_in;
                    if ((a_in == '0) && (b_in == '0)) begin
                        gcd_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if ((a_in == '0) || (b_in == '0)) begin
                        // One side is zero, so OR yields the other operand.
                        gcd_d   = a_in | b_in;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (a_gt_b) begin
                    a_d = a_q - b_q;
                end else if (a_lt_b) begin
                    b_d = b_q - a_q;
                end else begin
                    gcd_d   = a_q;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign gcd_out = gcd_q;
    assign err     = err_q;

endmodule : gcd_core

// File: tb/tb_gcd_core.sv
module tb_gcd_core;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] gcd_out;
    logic       err;

    int checks = 0;
    int errors = 0;

    gcd_core #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .gcd_out (gcd_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands with start for one edge (E0); returns at E0 + 1.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen; busy must stay high meanwhile.
    task automatic wait_done(output int n, output bit busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        while (!done && n < 300) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, err, gcd_out} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b gcd=%0d want all 0",
                     busy, done, err, gcd_out);
        end
    endtask

    task automatic test_basic;
        int n;
        bit bok;
        launch(8'd12, 8'd18);
        wait_done(n, bok);
        checks++;
        if (done !== 1'b1 || n !== 3 || gcd_out !== 8'd6 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_12_18: got done=%0b n=%0d gcd=%0d err=%0b want done=1 n=3 gcd=6 err=0",
                     done, n, gcd_out, err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got done=%0b busy=%0b want 0 0", done, busy);
        end
    endtask

    task automatic test_worst_case;
        int n;
        bit bok;
        launch(8'd255, 8'd1);
        wait_done(n, bok);
        checks++;
        if (done !== 1'b1 || n !== 255 || gcd_out !== 8'd1 || !bok) begin
            errors++;
            $display("FAIL worst_255_1: got done=%0b n=%0d gcd=%0d busy_ok=%0b want done=1 n=255 gcd=1 busy_ok=1",
                     done, n, gcd_out, bok);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero;
        int n;
        bit bok;
        launch(8'd0, 8'd9);
        wait_done(n, bok);
        checks++;
        if (done !== 1'b1 || n !== 0 || gcd_out !== 8'd9 || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_0_9: got done=%0b n=%0d gcd=%0d err=%0b want done=1 n=0 gcd=9 err=0",
                     done, n, gcd_out, err);
        end
        @(posedge clk);
        #1;
        launch(8'd7, 8'd0);
        wait_done(n, bok);
        checks++;
        if (done !== 1'b1 || n !== 0 || gcd_out !== 8'd7 || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_7_0: got done=%0b n=%0d gcd=%0d err=%0b want done=1 n=0 gcd=7 err=0",
                     done, n, gcd_out, err);
        end
        @(posedge clk);
        #1;
        launch(8'd0, 8'd0);
        wait_done(n, bok);
        checks++;
        if (done !== 1'b1 || n !== 0 || gcd_out !== 8'd0 || err !== 1'b1) begin
            errors++;
            $display("FAIL zero_0_0: got done=%0b n=%0d gcd=%0d err=%0b want done=1 n=0 gcd=0 err=1",
                     done, n, gcd_out, err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || gcd_out !== 8'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL err_hold: got err=%0b gcd=%0d done=%0b want err=1 gcd=0 done=0",
                     err, gcd_out, done);
        end
    endtask

    task automatic test_ignore_busy;
        int n;
        bit bok;
        launch(8'd21, 8'd14);
        checks++;
        if (gcd_out !== 8'd0 || err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_during_calc: got gcd=%0d err=%0b busy=%0b want gcd=0 err=1 busy=1",
                     gcd_out, err, busy);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = 8'd5;
        b_in  = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, bok);
        checks++;
        if (done !== 1'b1 || n !== 1 || gcd_out !== 8'd7 || err !== 1'b0) begin
            errors++;
            $display("FAIL ignore_21_14: got done=%0b n_rem=%0d gcd=%0d err=%0b want done=1 n_rem=1 gcd=7 err=0",
                     done, n, gcd_out, err);
        end
        @(posedge clk);
        #1;
        launch(8'd5, 8'd5);
        wait_done(n, bok);
        checks++;
        if (done !== 1'b1 || n !== 1 || gcd_out !== 8'd5) begin
            errors++;
            $display("FAIL equal_5_5: got done=%0b n=%0d gcd=%0d want done=1 n=1 gcd=5",
                     done, n, gcd_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_calc;
        int n;
        bit bok;
        launch(8'd200, 8'd3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, gcd_out} !== 11'b0 || dut.a_q !== 8'd0 || dut.b_q !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_calc: got busy=%0b done=%0b err=%0b gcd=%0d a=%0d b=%0d want all 0",
                     busy, done, err, gcd_out, dut.a_q, dut.b_q);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: got done=%0b busy=%0b want 0 0", done, busy);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(8'd8, 8'd12);
        wait_done(n, bok);
        checks++;
        if (done !== 1'b1 || n !== 3 || gcd_out !== 8'd4 || err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_8_12: got done=%0b n=%0d gcd=%0d err=%0b want done=1 n=3 gcd=4 err=0",
                     done, n, gcd_out, err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int n;
        bit bok;
        start = 1'b1;
        a_in  = 8'd6;
        b_in  = 8'd4;
        @(posedge clk);
        #1;
        wait_done(n, bok);
        checks++;
        if (done !== 1'b1 || n !== 3 || gcd_out !== 8'd2) begin
            errors++;
            $display("FAIL held_6_4: got done=%0b n=%0d gcd=%0d want done=1 n=3 gcd=2",
                     done, n, gcd_out);
        end
        a_in = 8'd9;
        b_in = 8'd3;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL held_idle_gap: got busy=%0b done=%0b want 0 0", busy, done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL held_restart: got busy=%0b done=%0b want 1 0", busy, done);
        end
        wait_done(n, bok);
        checks++;
        if (done !== 1'b1 || n !== 3 || gcd_out !== 8'd3) begin
            errors++;
            $display("FAIL held_9_3: got done=%0b n=%0d gcd=%0d want done=1 n=3 gcd=3",
                     done, n, gcd_out);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || gcd_out !== 8'd3) begin
            errors++;
            $display("FAIL held_release: got busy=%0b gcd=%0d want busy=0 gcd=3", busy, gcd_out);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #3;
        test_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_worst_case();
        test_zero();
        test_ignore_busy();
        test_reset_mid_calc();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gcd_core
